// File: rtl/riscv_hart.sv
// riscv_hart: single-issue, in-order RV32I-subset core with a 5-stage
// pipeline (IF/ID/EX/MEM/WB).
//
// The pipeline has no hazard detection, no forwarding and no branches.
// Software is expected to place NOPs between dependent instructions.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   instruction  word from the registered imem, one cycle after pc
//   pc           byte address of the next fetch (advances by 4 every cycle)
//   mem_read     word from the registered dmem, one cycle after mem_addr
//   mem_addr     data byte address (rs1+imm); carries ALU results otherwise
//   mem_data     store data (rs2)
//   mem_write    1 = dmem stores mem_data at mem_addr on the next edge
//
// Stage registers
//   id_*   instruction being decoded; the register file is read here
//   ex_*   ALU result / address, store data, destination and kind
//   mem_*  drives the dmem ports; ALU results retire from here into rd
//   wb_*   pending load; it captures mem_read into rd one edge later
module riscv_hart #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] mem_read,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_data,
  output logic            mem_write
);

  localparam logic [31:0] NOP    = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  OP_REG = 7'b0110011;
  localparam logic [6:0]  LUI    = 7'b0110111;
  localparam logic [6:0]  AUIPC  = 7'b0010111;
  localparam logic [6:0]  LOAD   = 7'b0000011;
  localparam logic [6:0]  STORE  = 7'b0100011;

  logic [XLEN-1:0] rf [NREG];

  // The instruction bus holds garbage on the first edge after reset,
  // so fetch_valid keeps that word out of ID.
  logic            fetch_valid;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;

  logic [XLEN-1:0] ex_result, ex_sdata;
  logic [4:0]      ex_rd;
  logic            ex_wr, ex_load, ex_store;

  logic [4:0]      mem_rd;
  logic            mem_wr, mem_load;

  logic [4:0]      wb_rd;
  logic            wb_load;

  // Decode fields
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;

  assign opcode = id_inst[6:0];
  assign rd     = id_inst[11:7];
  assign f3     = id_inst[14:12];
  assign rs1    = id_inst[19:15];
  assign rs2    = id_inst[24:20];
  assign imm_i  = XLEN'($signed(id_inst[31:20]));
  assign imm_s  = XLEN'($signed({id_inst[31:25], id_inst[11:7]}));
  assign imm_u  = XLEN'($signed({id_inst[31:12], 12'b0}));

  // Register read with write-before-read bypass. Both retiring writers
  // are visible to ID in the cycle they write. The ALU writer is the
  // younger instruction, so it is checked last and wins a tie. Writes to
  // x0 are dropped before they reach ex_wr/ex_load, so x0 never matches.
  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = rf[rs1];
    rs2_val = rf[rs2];
    if (wb_load && wb_rd == rs1) rs1_val = mem_read;
    if (wb_load && wb_rd == rs2) rs2_val = mem_read;
    if (mem_wr && mem_rd == rs1) rs1_val = mem_addr;
    if (mem_wr && mem_rd == rs2) rs2_val = mem_addr;
  end

  // Decode and ALU. Loads, stores, LUI and AUIPC reuse the adder.
  logic [XLEN-1:0] alu_a, alu_b, alu_res;
  logic [2:0]      alu_f3;
  logic            alu_alt, d_wr, d_load, d_store;

  always_comb begin
    alu_a   = rs1_val;
    alu_b   = imm_i;
    alu_f3  = f3;
    alu_alt = 1'b0;
    d_wr    = 1'b0;
    d_load  = 1'b0;
    d_store = 1'b0;
    case (opcode)
      OP_IMM: begin
        d_wr    = 1'b1;
        // For ADDI, bit 30 belongs to the immediate, so it only selects SRAI.
        alu_alt = (f3 == 3'b101) && id_inst[30];
      end
      OP_REG: begin
        d_wr    = 1'b1;
        alu_b   = rs2_val;
        alu_alt = id_inst[30];
      end
      LUI: begin
        d_wr   = 1'b1;
        alu_a  = '0;
        alu_b  = imm_u;
        alu_f3 = 3'b000;
      end
      AUIPC: begin
        d_wr   = 1'b1;
        alu_a  = id_pc;
        alu_b  = imm_u;
        alu_f3 = 3'b000;
      end
      LOAD: begin
        alu_f3 = 3'b000;
        d_load = (f3 == 3'b010);
      end
      STORE: begin
        alu_f3  = 3'b000;
        alu_b   = imm_s;
        d_store = (f3 == 3'b010);
      end
      default: ;
    endcase

    case (alu_f3)
      3'b000:  alu_res = alu_alt ? alu_a - alu_b : alu_a + alu_b;
      3'b001:  alu_res = alu_a << alu_b[4:0];
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      3'b100:  alu_res = alu_a ^ alu_b;
      3'b101:  alu_res = alu_alt ? XLEN'($signed(alu_a) >>> alu_b[4:0])
                                 : alu_a >> alu_b[4:0];
      3'b110:  alu_res = alu_a | alu_b;
      default: alu_res = alu_a & alu_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= '0;
      fetch_valid <= 1'b0;
      id_inst     <= NOP;
      id_pc       <= '0;
      ex_result   <= '0;
      ex_sdata    <= '0;
      ex_rd       <= '0;
      ex_wr       <= 1'b0;
      ex_load     <= 1'b0;
      ex_store    <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_write   <= 1'b0;
      mem_rd      <= '0;
      mem_wr      <= 1'b0;
      mem_load    <= 1'b0;
      wb_rd       <= '0;
      wb_load     <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      // IF
      pc          <= pc + XLEN'(4);
      fetch_valid <= 1'b1;
      // ID: the word on the bus was fetched from the previous pc.
      id_inst     <= fetch_valid ? instruction : NOP;
      id_pc       <= pc - XLEN'(4);
      // EX
      ex_result   <= alu_res;
      ex_sdata    <= rs2_val;
      ex_rd       <= rd;
      ex_wr       <= d_wr && (rd != 5'd0);
      ex_load     <= d_load && (rd != 5'd0);
      ex_store    <= d_store;
      // MEM
      mem_addr    <= ex_result;
      mem_data    <= ex_sdata;
      mem_write   <= ex_store;
      mem_rd      <= ex_rd;
      mem_wr      <= ex_wr;
      mem_load    <= ex_load;
      // WB. A load retires one edge after the ALU op behind it, so both
      // can write on the same edge. The ALU op is younger and is written
      // second so that it wins a tie.
      wb_rd       <= mem_rd;
      wb_load     <= mem_load;
      if (wb_load) rf[wb_rd] <= mem_read;
      if (mem_wr)  rf[mem_rd] <= mem_addr;
    end
  end

endmodule

// File: tb/tb_riscv_hart.sv
// Directed bench for riscv_hart. It models registered instruction and data
// memories (64 words each), loads small hand-assembled programs, and checks
// pc, the dmem port and the dmem contents against hand-computed values.
module tb_riscv_hart;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_write;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  riscv_hart #(.XLEN(32), .NREG(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .pc          (pc),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_write   (mem_write)
  );

  // ---------------- clock / memories ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    instruction <= imem[pc[7:2]];
    mem_read    <= dmem[mem_addr[7:2]];
    if (mem_write) dmem[mem_addr[7:2]] = mem_data;
  end

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_sw(logic [4:0] rs2, logic [11:0] imm, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      imem[i] = NOP;
      dmem[i] = 32'h0;
    end
  endtask

  task automatic put(input logic [7:0] addr, input logic [31:0] word);
    imem[addr[7:2]] = word;
  endtask

  // Hold reset for the given number of edges, checking pc and mem_write.
  // Returns just before edge 1.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_pc", pc, 32'h0);
      check_eq("rst_mem_write", {31'b0, mem_write}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  initial begin
    instruction = NOP;
    mem_read    = 32'h0;

    // Reset and pc sequence
    clear_mem();
    do_reset(2);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check_eq("pc_seq", pc, 32'(4 * k));
    end

    // Two ADDIs stored by two SWs; check the mem_write window
    clear_mem();
    put(0,  addi(5'd5, 5'd0, 12'd42));
    put(4,  addi(5'd1, 5'd0, 12'd77));
    put(20, enc_sw(5'd5, 12'd12, 5'd0));
    put(24, enc_sw(5'd1, 12'd8, 5'd0));
    do_reset(2);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check_eq("sw_mem_write", {31'b0, mem_write}, (k == 9 || k == 10) ? 32'd1 : 32'd0);
      if (k == 9) begin
        check_eq("sw_addr", mem_addr, 32'd12);
        check_eq("sw_data", mem_data, 32'd42);
        check_eq("dmem12_before", dmem[3], 32'd0);
      end
      if (k == 10) check_eq("dmem12", dmem[3], 32'd42);
      if (k == 11) check_eq("dmem8", dmem[2], 32'd77);
    end

    // x0 stays zero
    clear_mem();
    dmem[0] = 32'hDEAD_BEEF;
    put(0,  addi(5'd0, 5'd0, 12'd5));
    put(16, enc_sw(5'd0, 12'd0, 5'd0));
    do_reset(2);
    step(11);
    check_eq("x0_zero", dmem[0], 32'h0);

    // Logical vs arithmetic right shift
    clear_mem();
    put(0,  addi(5'd2, 5'd0, 12'hFFF));
    put(16, enc_i(12'h01C, 5'd2, 3'b101, 5'd3, 7'b0010011));
    put(20, enc_i(12'h41C, 5'd2, 3'b101, 5'd4, 7'b0010011));
    put(36, enc_sw(5'd3, 12'd0, 5'd0));
    put(40, enc_sw(5'd4, 12'd4, 5'd0));
    do_reset(2);
    step(17);
    check_eq("srli", dmem[0], 32'h0000_000F);
    check_eq("srai", dmem[1], 32'hFFFF_FFFF);

    // Load then store
    clear_mem();
    dmem[4] = 32'd123;
    put(0,  enc_i(12'd16, 5'd0, 3'b010, 5'd6, 7'b0000011));
    put(20, enc_sw(5'd6, 12'd20, 5'd0));
    do_reset(2);
    step(12);
    check_eq("lw_sw", dmem[5], 32'd123);

    // ALU mix: x1=100, x2=-7
    clear_mem();
    for (int i = 0; i < 9; i++) dmem[i] = 32'hA5A5_A5A5;
    put(0,  addi(5'd1, 5'd0, 12'd100));
    put(4,  addi(5'd2, 5'd0, 12'hFF9));
    put(20, enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3));        // SUB
    put(24, enc_r(7'b0000000, 5'd1, 5'd2, 3'b010, 5'd4));        // SLT
    put(28, enc_r(7'b0000000, 5'd1, 5'd2, 3'b011, 5'd5));        // SLTU
    put(32, enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd6));        // XOR
    put(36, enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd7));        // AND
    put(40, {20'h12345, 5'd8, 7'b0110111});                      // LUI
    put(44, {20'h00001, 5'd9, 7'b0010111});                      // AUIPC
    put(48, enc_i(12'hFFF, 5'd1, 3'b011, 5'd10, 7'b0010011));    // SLTIU
    put(52, enc_r(7'b0000000, 5'd4, 5'd1, 3'b001, 5'd11));       // SLL
    for (int i = 0; i < 9; i++)
      put(8'(68 + 4 * i), enc_sw(5'(3 + i), 12'(4 * i), 5'd0));
    exp_q.push_back(32'd107);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hFFFF_FF9D);
    exp_q.push_back(32'h0000_0060);
    exp_q.push_back(32'h1234_5000);
    exp_q.push_back(32'h0000_102C);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd200);
    do_reset(2);
    step(32);
    for (int i = 0; i < 9; i++) check_eq($sformatf("alu_mix[%0d]", i), dmem[i], exp_q.pop_front());

    // Reset while a SW is in EX
    clear_mem();
    put(0,  addi(5'd5, 5'd0, 12'd42));
    put(16, enc_sw(5'd5, 12'd12, 5'd0));
    do_reset(2);
    step(7);
    do_reset(2);
    check_eq("mid_rst_no_write", dmem[3], 32'h0);
    step(1);
    check_eq("restart_pc", pc, 32'd4);
    step(7);
    check_eq("restart_before", dmem[3], 32'h0);
    step(1);
    check_eq("restart_write", dmem[3], 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
